// File: rtl/pe_array_ctrl_pkg.sv
// Shared definitions for the PE array sequencer.
//   state_e        : sequencer FSM states
//   diag_width()   : number of anti-diagonals in an S x S array (2S-1)
//   row_idx_width(): bits needed to name one of S rows
package pe_array_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCompute = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } state_e;

  function automatic int unsigned diag_width(input int unsigned s);
    return 2 * s - 1;
  endfunction

  function automatic int unsigned row_idx_width(input int unsigned s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// OFM drain handshake between the sequencer (master) and the PE array / OFM writer (slave).
//   ofm_write_en  : array in write/drain mode
//   psum_down_en  : psums shift down one row this cycle
//   set_reg_write : bit r enables the psum shift into row r+1
//   ofm_valid     : bottom-row result is valid
//   ofm_row_idx   : logical row of the presented result
//   ofm_ready     : OFM writer accepts the result
interface pe_array_ctrl_if
  import pe_array_ctrl_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = 16
);
  localparam int unsigned RowW = row_idx_width(SYSTOLIC_SIZE);

  logic                     ofm_write_en;
  logic                     psum_down_en;
  logic [SYSTOLIC_SIZE-2:0] set_reg_write;
  logic                     ofm_valid;
  logic [RowW-1:0]          ofm_row_idx;
  logic                     ofm_ready;

  modport master (
    output ofm_write_en, psum_down_en, set_reg_write, ofm_valid, ofm_row_idx,
    input  ofm_ready
  );

  modport slave (
    input  ofm_write_en, psum_down_en, set_reg_write, ofm_valid, ofm_row_idx,
    output ofm_ready
  );
endinterface

// File: rtl/pe_array_ctrl_diag_strobe_gen.sv
// Anti-diagonal accumulator-load strobe decoder.
//   en_i     : sequencer is in COMPUTE
//   t_i      : COMPUTE cycle counter
//   strobe_o : one-hot; bit d is high when t_i == d+1, all zero outside t_i = 1..2S-1
module diag_strobe_gen
  import pe_array_ctrl_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned TW            = 17
) (
  input  logic                                  en_i,
  input  logic [TW-1:0]                         t_i,
  output logic [diag_width(SYSTOLIC_SIZE)-1:0]  strobe_o
);
  localparam int unsigned DiagW = diag_width(SYSTOLIC_SIZE);

  logic in_window;
  assign in_window = en_i && (t_i != '0) && (t_i <= TW'(DiagW));

  always_comb begin
    strobe_o = '0;
    for (int unsigned d = 0; d < DiagW; d++) begin
      strobe_o[d] = in_window && (t_i == TW'(d + 1));
    end
  end
endmodule

// File: rtl/pe_array_ctrl.sv
// Systolic PE array sequencer: issues k_len operand reads, strobes each anti-diagonal's
// accumulators as the skewed wavefront passes, then drains one row per OFM handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   start, k_len        : tile request and accumulation depth (sampled in IDLE)
//   busy, done          : status; done is a one-cycle end-of-tile pulse
//   rd_en, rd_addr      : operand buffer read strobe and index
//   set_reg_compute     : one-hot anti-diagonal accumulator-load strobe
//   ofm                 : drain handshake bundle (master side)
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned K_WIDTH       = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [K_WIDTH-1:0]                   k_len,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rd_en,
  output logic [K_WIDTH-1:0]                   rd_addr,
  output logic [diag_width(SYSTOLIC_SIZE)-1:0] set_reg_compute,
  pe_array_ctrl_if.master                      ofm
);
  localparam int unsigned S    = SYSTOLIC_SIZE;
  localparam int unsigned RowW = row_idx_width(S);
  // One extra bit so k_len + 2S - 2 never wraps.
  localparam int unsigned TW   = K_WIDTH + 1;

  if (SYSTOLIC_SIZE < 2 || DATA_WIDTH == 0) begin : gen_bad_params
    $error("pe_array_ctrl: SYSTOLIC_SIZE must be >= 2 and DATA_WIDTH nonzero");
  end

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [RowW-1:0]   c_q, c_d;

  logic              in_compute, in_drain, hs;
  logic [TW-1:0]     t_last;
  logic [S-2:0]      srw;

  assign in_compute = (state_q == StCompute);
  assign in_drain   = (state_q == StDrain);
  assign hs         = in_drain && ofm.ofm_ready;
  assign t_last     = {1'b0, k_q} + TW'(2 * S - 2);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    c_d     = c_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (k_len != '0) begin
            k_d     = k_len;
            t_d     = '0;
            state_d = StCompute;
          end else begin
            state_d = StDone;
          end
        end
      end
      StCompute: begin
        if (t_q == t_last) begin
          c_d     = '0;
          state_d = StDrain;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDrain: begin
        if (hs) begin
          if (c_q == RowW'(S - 1)) state_d = StDone;
          else                     c_d = c_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      k_q     <= k_d;
      c_q     <= c_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign rd_en   = in_compute && (t_q < {1'b0, k_q});
  assign rd_addr = rd_en ? t_q[K_WIDTH-1:0] : '0;

  diag_strobe_gen #(
    .SYSTOLIC_SIZE(S),
    .TW           (TW)
  ) u_diag_strobe_gen (
    .en_i    (in_compute),
    .t_i     (t_q),
    .strobe_o(set_reg_compute)
  );

  // Rows already drained stop shifting, so the enable shrinks as c advances.
  always_comb begin
    srw = '0;
    for (int unsigned r = 0; r < S - 1; r++) begin
      srw[r] = hs && (RowW'(r) >= c_q);
    end
  end

  assign ofm.ofm_write_en  = in_drain;
  assign ofm.ofm_valid     = in_drain;
  assign ofm.ofm_row_idx   = in_drain ? (RowW'(S - 1) - c_q) : '0;
  assign ofm.psum_down_en  = hs;
  assign ofm.set_reg_write = srw;
endmodule

// File: tb/tb_pe_array_ctrl.sv
module tb_pe_array_ctrl;
  localparam int S  = 4;
  localparam int KW = 8;

  typedef struct {
    int cyc;
    int val;
    int aux;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done, rd_en;
  logic [KW-1:0] rd_addr;
  logic [2*S-2:0] set_reg_compute;

  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;
  int stall_lo = 0;
  int stall_hi = 0;

  exp_t q_rd[$];
  exp_t q_stb[$];
  exp_t q_ofm[$];
  int   q_done[$];

  pe_array_ctrl_if #(.SYSTOLIC_SIZE(S)) ofm_if ();

  pe_array_ctrl #(
    .DATA_WIDTH   (8),
    .SYSTOLIC_SIZE(S),
    .K_WIDTH      (KW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .k_len          (k_len),
    .busy           (busy),
    .done           (done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .set_reg_compute(set_reg_compute),
    .ofm            (ofm_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // OFM writer: ready except inside the planned stall window.
  always @(posedge clk) begin
    #1;
    ofm_if.ofm_ready = !((cyc >= stall_lo) && (cyc < stall_hi));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int thermo(input int c);
    return ((1 << (S - 1)) - 1) & ~((1 << c) - 1);
  endfunction

  // Scoreboard monitor: every observed output event pops its expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    int   dc;
    if (!rst) begin
      if (rd_en) begin
        if (q_rd.size() == 0) check_eq("rd_extra", rd_en, 0);
        else begin
          e = q_rd.pop_front();
          check_eq("rd_cyc", cyc, e.cyc);
          check_eq("rd_addr", rd_addr, e.val);
        end
      end
      if (set_reg_compute != '0) begin
        if (q_stb.size() == 0) check_eq("stb_extra", set_reg_compute, 0);
        else begin
          e = q_stb.pop_front();
          check_eq("stb_cyc", cyc, e.cyc);
          check_eq("stb_val", set_reg_compute, e.val);
        end
      end
      if (ofm_if.ofm_valid) begin
        check_eq("wr_en", ofm_if.ofm_write_en, 1);
        if (q_ofm.size() == 0) check_eq("ofm_extra", ofm_if.ofm_valid, 0);
        else if (ofm_if.ofm_ready) begin
          e = q_ofm.pop_front();
          check_eq("ofm_cyc", cyc, e.cyc);
          check_eq("row_idx", ofm_if.ofm_row_idx, e.val);
          check_eq("thermo", ofm_if.set_reg_write, e.aux);
          check_eq("psum_en", ofm_if.psum_down_en, 1);
        end else begin
          check_eq("stall_row", ofm_if.ofm_row_idx, q_ofm[0].val);
          check_eq("stall_psum", ofm_if.psum_down_en, 0);
          check_eq("stall_srw", ofm_if.set_reg_write, 0);
        end
      end else if (ofm_if.psum_down_en) begin
        check_eq("psum_extra", ofm_if.psum_down_en, 0);
      end
      if (done) begin
        if (q_done.size() == 0) check_eq("done_extra", done, 0);
        else begin
          dc = q_done.pop_front();
          check_eq("done_cyc", cyc, dc);
          check_eq("done_busy", busy, 1);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_rd_en"}, rd_en, 0);
    check_eq({tag, "_rd_addr"}, rd_addr, 0);
    check_eq({tag, "_stb"}, set_reg_compute, 0);
    check_eq({tag, "_srw"}, ofm_if.set_reg_write, 0);
    check_eq({tag, "_wr_en"}, ofm_if.ofm_write_en, 0);
    check_eq({tag, "_psum"}, ofm_if.psum_down_en, 0);
    check_eq({tag, "_valid"}, ofm_if.ofm_valid, 0);
    check_eq({tag, "_row"}, ofm_if.ofm_row_idx, 0);
  endtask

  // Issue one tile and push every expected event; stall is the number of ready-low
  // cycles while row c=1 is presented.
  task automatic run_tile(input int k, input int stall);
    int s0, f;
    @(posedge clk);
    #1;
    s0    = cyc;
    start = 1'b1;
    k_len = KW'(k);
    if (k == 0) begin
      q_done.push_back(s0 + 1);
    end else begin
      for (int a = 0; a < k; a++) q_rd.push_back('{s0 + 1 + a, a, 0});
      for (int d = 0; d < 2 * S - 1; d++) q_stb.push_back('{s0 + 2 + d, 1 << d, 0});
      f = s0 + k + 2 * S;
      for (int c = 0; c < S; c++)
        q_ofm.push_back('{f + c + ((c >= 1) ? stall : 0), S - 1 - c, thermo(c)});
      stall_lo = f + 1;
      stall_hi = f + 1 + stall;
      q_done.push_back(s0 + k + 3 * S + stall);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || (q_rd.size() + q_stb.size() + q_ofm.size() + q_done.size()) != 0)
           && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("idle_in_time", n < 600, 1);
    check_eq("q_left", q_rd.size() + q_stb.size() + q_ofm.size() + q_done.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Basic tile, continuous handshakes (thermometer 111,110,100,000).
    run_tile(5, 0);
    wait_idle();

    // Backpressure at c=1.
    run_tile(5, 3);
    wait_idle();

    // Zero depth.
    run_tile(0, 0);
    wait_idle();

    // Depth 1 and maximum depth.
    run_tile(1, 0);
    wait_idle();
    run_tile(255, 2);
    wait_idle();

    // Start pulsed during drain must be ignored.
    run_tile(3, 0);
    n = 0;
    while (!ofm_if.ofm_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_seen", ofm_if.ofm_valid, 1);
    start = 1'b1;
    k_len = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-COMPUTE.
    run_tile(5, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    q_rd.delete();
    q_stb.delete();
    q_ofm.delete();
    q_done.delete();
    stall_lo = 0;
    stall_hi = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Recovery after reset.
    run_tile(2, 1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
